// File: rtl/sll_seq_pkg.sv
// Shared constants and state encodings for the sequential left shifter.
package sll_seq_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned SHAMT_WIDTH = 5;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Shift distance applied by stage k (one power of two per shamt bit).
  function automatic int unsigned stage_amt(input int unsigned k);
    return 32'(1) << k;
  endfunction

endpackage

// File: rtl/sll_seq_shift_l_stage.sv
// Fixed-distance logical left shift with zero fill.
module shift_l_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT   = 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  // Bits pushed past the MSB are discarded by the fixed result width.
  assign out_o = in_i << AMT;

endmodule

// File: rtl/sll_seq.sv
// Sequential logical left shifter: one power-of-two stage per cycle,
// highest stage first, fixed latency regardless of shift amount.
module sll_seq
  import sll_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_WIDTH,
  parameter int unsigned SHAMT_W = SHAMT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               data_ready,
  output logic [WIDTH-1:0]   out
);

  localparam int unsigned K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  state_e             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   work_d;
  logic [SHAMT_W-1:0] shamt_q;
  logic [K_W-1:0]     k_q;
  logic [WIDTH-1:0]   out_q;
  logic               busy_q;
  logic               ready_q;

  logic [WIDTH-1:0]   stage_out [SHAMT_W];

  // One fixed shifter per stage; the stage counter picks which one applies.
  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    shift_l_stage #(
      .WIDTH (WIDTH),
      .AMT   (stage_amt(g))
    ) u_stage (
      .in_i  (work_q),
      .out_o (stage_out[g])
    );
  end

  // Next work value: shift by 2^k only when the captured shamt bit k is set.
  always_comb begin
    work_d = work_q;
    if (shamt_q[k_q]) begin
      work_d = stage_out[k_q];
    end
  end

  // Control FSM with registered outputs; reset wins over start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      shamt_q <= '0;
      k_q     <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            work_q  <= A;
            shamt_q <= shamt;
            k_q     <= K_W'(SHAMT_W - 1);
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (k_q == '0) begin
            // Final stage bypasses work_q so out only ever sees full results.
            out_q   <= work_d;
            work_q  <= work_d;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            work_q <= work_d;
            k_q    <= k_q - K_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign data_ready = ready_q;
  assign out        = out_q;

endmodule
